chronospatial_core_seq: RTL and testbench
=========================================

Name: chronospatial_core_seq

Overview:
- Parametrised, self-sequencing successor to the streamed 3-bit chronospatial processor.
- Program is loaded once into internal program memory as {opcode, operand} pairs; registers A/B/C are initialised; the core then runs autonomously at one instruction per cycle.
- Emits `out` values through an output FIFO with valid/ready backpressure.
- Adds a jump-alignment check and a step watchdog.

Parameters:
- A_WIDTH, 16, width of registers A, B and C (min 4).
- PROG_DEPTH, 16, program memory entries in pairs (power of 2, min 2).
- OUT_DEPTH, 4, output FIFO entries (power of 2, min 2).
- MAX_STEPS, 4096, instructions executed before watchdog error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- load_valid  in  1  write load_data to program memory.
- load_data  in  6  {opcode[5:3], operand[2:0]}.
- load_last  in  1  with load_valid: final pair of program.
- init_valid  in  1  load init_a/b/c into A/B/C.
- init_a  in  A_WIDTH  initial A.
- init_b  in  A_WIDTH  initial B.
- init_c  in  A_WIDTH  initial C.
- start  in  1  begin execution from pc 0.
- out_data  out  3  FIFO head value.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head.
- busy  out  1  state==RUN.
- halted  out  1  state==HALT.
- error  out  1  sticky error flag.
- instr_ptr  out  log2(PROG_DEPTH)+1  instruction pointer in 3-bit units (pc*2).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; A/B/C, pc, wr_ptr, prog_len, step count = 0.
  - FIFO emptied; outputs: out_valid=0, out_data=0, busy=0, halted=0, error=0, instr_ptr=0.
  - Program memory contents are not cleared. Reset mid-RUN aborts immediately.
- States:
  - IDLE: load/init accepted; start with prog_len≠0 → RUN. start with prog_len=0 → HALT, error=1.
  - RUN: executes instructions. Load, init and start are ignored.
  - HALT: same acceptance as IDLE; start → RUN.
- Load (IDLE/HALT only):
  - Each load_valid writes prog[wr_ptr], wr_ptr++.
  - load_last also sets prog_len=wr_ptr+1 and wr_ptr=0.
  - A write with wr_ptr==PROG_DEPTH is dropped and sets error=1.
- init_valid (IDLE/HALT only): A/B/C ← init values the same cycle. init_valid has priority over nothing else; it is independent of load.
- start edge into RUN: pc=0, step count=0, error=0; FIFO is not flushed.
- RUN, one instruction per cycle (combinational fetch of prog[pc]):
  - combo operand: 0–3 → literal; 4 → A; 5 → B; 6 → C; 7 → reserved: error=1, → HALT, no register write.
  - 0 adv: A=A>>combo.
  - 1 bxl: B=B^lit (zero-extended).
  - 2 bst: B=combo mod 8.
  - 3 jnz: if A≠0, pc=lit>>1; odd lit with A≠0 → error=1, HALT. If A=0, pc++.
  - 4 bxc: B=B^C.
  - 5 out: push combo mod 8.
  - 6 bdv: B=A>>combo.
  - 7 cdv: C=A>>combo.
  - Shift amount ≥A_WIDTH yields 0.
  - All non-jump instructions do pc++.
- Out stall: if the FIFO is full at the start of the cycle, the out instruction stalls (pc, regs and step count unchanged), even if a pop occurs in that cycle.
- Termination:
  - pc==prog_len at a cycle start → HALT (normal, error unchanged). A jump target ≥prog_len therefore halts next cycle.
  - Step count reaching MAX_STEPS → HALT, error=1. Stall cycles are not counted.
- FIFO: push and pop in the same cycle are both allowed when neither full-stalled nor empty; pop occurs when out_valid&&out_ready. out_data shows the head; it is 0 when empty.
- instr_ptr = {pc,1'b0}, updated every cycle pc changes.

Test Plan:
- Load pairs (0,1),(5,4),(3,0); init A=729, B=C=0; start; out_ready=1 → FIFO stream 4,6,3,5,6,3,5,2,1,0; halted=1, error=0, A=0, instr_ptr=6.
- Same program with A=2024 → 4,2,5,6,7,7,7,7,3,1,0.
- Program (2,6), C=9 → halted with B=1, no outputs.
- Program (5,0),(5,1),(5,4), A=10, out_ready=0 (OUT_DEPTH=2) → two outputs held, then core stalls with pc=2 and busy=1. Raise out_ready → 0,1,2 delivered in order, then HALT.
- Program (3,1), A=5 → error=1, halted=1 one cycle after start.
- Program (3,0), A=1, MAX_STEPS=8 → HALT with error=1 after 8 executed cycles.
- Reset asserted mid-run → all outputs return to reset values next edge; FIFO empty.

Source files
------------

// File: rtl/chronospatial_core_seq.sv
// Self-sequencing 3-bit chronospatial core.
// A program of {opcode, operand} pairs is loaded into an internal memory,
// registers A/B/C are initialised, and a start pulse runs the program at one
// instruction per cycle. Values produced by the out instruction leave through
// a small FIFO with valid/ready backpressure. Execution stops at the end of the
// program, on a fault (reserved combo operand, misaligned jump) or when the
// step watchdog expires.
module chronospatial_core_seq #(
   parameter int A_WIDTH    = 16,
   parameter int PROG_DEPTH = 16,
   parameter int OUT_DEPTH  = 4,
   parameter int MAX_STEPS  = 4096
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load_valid,
   input  logic [5:0]                  load_data,
   input  logic                        load_last,
   input  logic                        init_valid,
   input  logic [A_WIDTH-1:0]          init_a,
   input  logic [A_WIDTH-1:0]          init_b,
   input  logic [A_WIDTH-1:0]          init_c,
   input  logic                        start,
   output logic [2:0]                  out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy,
   output logic                        halted,
   output logic                        error,
   output logic [$clog2(PROG_DEPTH):0] instr_ptr
);

   localparam int PA = $clog2(PROG_DEPTH);   // program address bits
   localparam int PW = PA + 1;               // pc / length width, holds PROG_DEPTH
   localparam int OA = $clog2(OUT_DEPTH);    // FIFO address bits
   localparam int SW = $clog2(MAX_STEPS + 1);

   localparam logic [PW-1:0] PROG_FULL = PW'(PROG_DEPTH);
   localparam logic [OA:0]   OUT_FULL  = (OA + 1)'(OUT_DEPTH);
   localparam logic [SW-1:0] LAST_STEP = SW'(MAX_STEPS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

   state_t               state_q;
   logic [A_WIDTH-1:0]   a_q, b_q, c_q;
   logic [PW-1:0]        pc_q, wr_ptr_q, prog_len_q;
   logic [SW-1:0]        step_q;
   logic                 error_q;

   logic [5:0]           prog_mem [PROG_DEPTH];
   logic [2:0]           fifo_mem [OUT_DEPTH];
   logic [OA-1:0]        fifo_rd_q, fifo_wr_q;
   logic [OA:0]          fifo_cnt_q;

   // Decode / execute results for the instruction at pc
   logic [5:0]           instr;
   logic [2:0]           op, opd;
   logic [A_WIDTH-1:0]   combo, shr_a;
   logic                 uses_combo, at_end, fifo_full, pop;
   logic                 fault, exec_ok, push;
   logic [2:0]           push_val;
   logic [A_WIDTH-1:0]   a_d, b_d, c_d;
   logic [PW-1:0]        pc_d;
   logic                 load_wr_en;

   // pc never indexes past PROG_DEPTH-1 while executing: pc >= prog_len halts first
   assign instr      = prog_mem[pc_q[PA-1:0]];
   assign op         = instr[5:3];
   assign opd        = instr[2:0];
   assign at_end     = (pc_q >= prog_len_q);
   assign fifo_full  = (fifo_cnt_q == OUT_FULL);
   assign out_valid  = (fifo_cnt_q != '0);
   assign out_data   = out_valid ? fifo_mem[fifo_rd_q] : 3'd0;
   assign pop        = out_valid && out_ready;
   assign busy       = (state_q == ST_RUN);
   assign halted     = (state_q == ST_HALT);
   assign error      = error_q;
   assign instr_ptr  = {pc_q[PA-1:0], 1'b0};
   assign load_wr_en = rst_n && (state_q != ST_RUN) && load_valid && (wr_ptr_q != PROG_FULL);

   // Combo operand selection and the shared A >> combo result (logical shift gives 0 when combo >= A_WIDTH)
   always_comb begin
      combo = A_WIDTH'(opd);
      case (opd)
         3'd4:    combo = a_q;
         3'd5:    combo = b_q;
         3'd6:    combo = c_q;
         default: combo = A_WIDTH'(opd);
      endcase
      shr_a      = a_q >> combo;
      uses_combo = (op == 3'd0) || (op == 3'd2) || (op == 3'd5) || (op == 3'd6) || (op == 3'd7);
   end

   // Execute one instruction: faults beat stalls, stalls beat execution
   always_comb begin
      fault    = 1'b0;
      exec_ok  = 1'b0;
      push     = 1'b0;
      push_val = combo[2:0];
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      pc_d     = pc_q + 1'b1;
      if (state_q == ST_RUN && !at_end) begin
         if (uses_combo && opd == 3'd7) begin
            fault = 1'b1;
         end else if (op == 3'd3 && a_q != '0 && opd[0]) begin
            fault = 1'b1;
         end else if (op == 3'd5 && fifo_full) begin
            exec_ok = 1'b0;   // out stalls; nothing advances this cycle
         end else begin
            exec_ok = 1'b1;
            case (op)
               3'd0: a_d = shr_a;
               3'd1: b_d = b_q ^ A_WIDTH'(opd);
               3'd2: b_d = A_WIDTH'(combo[2:0]);
               3'd3: if (a_q != '0) pc_d = PW'(opd[2:1]);
               3'd4: b_d = b_q ^ c_q;
               3'd5: push = 1'b1;
               3'd6: b_d = shr_a;
               default: c_d = shr_a;
            endcase
         end
      end
   end

   // Control FSM: load/init/start while stopped, instruction retirement while running
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         pc_q       <= '0;
         wr_ptr_q   <= '0;
         prog_len_q <= '0;
         step_q     <= '0;
         error_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (at_end) begin
                  state_q <= ST_HALT;
               end else if (fault) begin
                  error_q <= 1'b1;
                  state_q <= ST_HALT;
               end else if (exec_ok) begin
                  a_q    <= a_d;
                  b_q    <= b_d;
                  c_q    <= c_d;
                  pc_q   <= pc_d;
                  step_q <= step_q + 1'b1;
                  if (step_q == LAST_STEP) begin
                     error_q <= 1'b1;
                     state_q <= ST_HALT;
                  end
               end
            end
            default: begin
               if (load_valid) begin
                  if (wr_ptr_q == PROG_FULL) begin
                     // Overflowing write is dropped; a last flag still closes the program
                     error_q <= 1'b1;
                     if (load_last) begin
                        wr_ptr_q   <= '0;
                        prog_len_q <= PROG_FULL;
                     end
                  end else if (load_last) begin
                     prog_len_q <= wr_ptr_q + 1'b1;
                     wr_ptr_q   <= '0;
                  end else begin
                     wr_ptr_q <= wr_ptr_q + 1'b1;
                  end
               end
               if (init_valid) begin
                  a_q <= init_a;
                  b_q <= init_b;
                  c_q <= init_c;
               end
               // Start sees the program length from before this cycle's load
               if (start) begin
                  if (prog_len_q != '0) begin
                     state_q <= ST_RUN;
                     pc_q    <= '0;
                     step_q  <= '0;
                     error_q <= 1'b0;
                  end else begin
                     state_q <= ST_HALT;
                     error_q <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Program memory write port (contents survive reset)
   always_ff @(posedge clk) begin
      if (load_wr_en) begin
         prog_mem[wr_ptr_q[PA-1:0]] <= load_data;
      end
   end

   // Output FIFO storage
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         fifo_mem[fifo_wr_q] <= push_val;
      end
   end

   // Output FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fifo_rd_q  <= '0;
         fifo_wr_q  <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) fifo_wr_q <= fifo_wr_q + 1'b1;
         if (pop)  fifo_rd_q <= fifo_rd_q + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_chronospatial_core_seq.sv
// Bench for chronospatial_core_seq: behavioural model stepped every clock,
// outputs compared each cycle, plus directed programs with literal results.
module tb_chronospatial_core_seq;

   localparam int AW  = 16;
   localparam int PD  = 16;
   localparam int OD  = 2;
   localparam int MS  = 64;
   localparam int IPW = $clog2(PD) + 1;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           load_valid = 1'b0;
   logic [5:0]     load_data = '0;
   logic           load_last = 1'b0;
   logic           init_valid = 1'b0;
   logic [AW-1:0]  init_a = '0, init_b = '0, init_c = '0;
   logic           start = 1'b0;
   logic [2:0]     out_data;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic           busy, halted, error;
   logic [IPW-1:0] instr_ptr;

   int tests = 0;
   int fails = 0;
   int cycle = 0;

   // model state
   int            m_mode = M_IDLE;
   logic [AW-1:0] m_a = '0, m_b = '0, m_c = '0;
   int            m_pc = 0, m_len = 0, m_wr = 0, m_steps = 0;
   bit            m_err = 1'b0;
   logic [5:0]    m_prog [PD];
   logic [2:0]    m_fifo [$];

   logic [2:0]    dut_out [$];
   logic [5:0]    prog_q [$];

   chronospatial_core_seq #(
      .A_WIDTH(AW), .PROG_DEPTH(PD), .OUT_DEPTH(OD), .MAX_STEPS(MS)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .init_valid(init_valid), .init_a(init_a), .init_b(init_b), .init_c(init_c),
      .start(start),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .halted(halted), .error(error), .instr_ptr(instr_ptr)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("[TB] FAIL global timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [AW-1:0] shr(input logic [AW-1:0] v, input logic [AW-1:0] amt);
      if (int'(amt) >= AW) return '0;
      return v >> amt;
   endfunction

   // One clock edge of the architectural model, using the inputs applied at that edge
   task automatic model_step();
      int old_len, op, opd;
      bit full, pop, do_push, uses;
      logic [AW-1:0] cv;
      logic [5:0] ins;
      logic [2:0] pv;
      if (!rst_n) begin
         m_mode = M_IDLE; m_a = '0; m_b = '0; m_c = '0;
         m_pc = 0; m_len = 0; m_wr = 0; m_steps = 0; m_err = 1'b0;
         m_fifo.delete();
         return;
      end
      full    = (m_fifo.size() == OD);
      pop     = (m_fifo.size() > 0) && out_ready;
      do_push = 1'b0;
      pv      = '0;
      if (m_mode != M_RUN) begin
         old_len = m_len;
         if (load_valid) begin
            if (m_wr == PD) begin
               m_err = 1'b1;
               if (load_last) begin m_wr = 0; m_len = PD; end
            end else begin
               m_prog[m_wr] = load_data;
               if (load_last) begin m_len = m_wr + 1; m_wr = 0; end
               else m_wr++;
            end
         end
         if (init_valid) begin m_a = init_a; m_b = init_b; m_c = init_c; end
         if (start) begin
            if (old_len != 0) begin
               m_mode = M_RUN; m_pc = 0; m_steps = 0; m_err = 1'b0;
            end else begin
               m_mode = M_HALT; m_err = 1'b1;
            end
         end
      end else if (m_pc >= m_len) begin
         m_mode = M_HALT;
      end else begin
         ins  = m_prog[m_pc];
         op   = int'(ins[5:3]);
         opd  = int'(ins[2:0]);
         cv   = (opd < 4) ? AW'(opd) : (opd == 4) ? m_a : (opd == 5) ? m_b : m_c;
         uses = (op == 0) || (op == 2) || (op == 5) || (op == 6) || (op == 7);
         if (uses && opd == 7) begin
            m_err = 1'b1; m_mode = M_HALT;
         end else if (op == 3 && m_a != 0 && (opd % 2) == 1) begin
            m_err = 1'b1; m_mode = M_HALT;
         end else if (op == 5 && full) begin
            // stalled
         end else begin
            m_pc++;
            case (op)
               0: m_a = shr(m_a, cv);
               1: m_b = m_b ^ AW'(opd);
               2: m_b = AW'(cv % 8);
               3: if (m_a != 0) m_pc = opd / 2;
               4: m_b = m_b ^ m_c;
               5: begin do_push = 1'b1; pv = 3'(cv % 8); end
               6: m_b = shr(m_a, cv);
               default: m_c = shr(m_a, cv);
            endcase
            m_steps++;
            if (m_steps == MS) begin m_err = 1'b1; m_mode = M_HALT; end
         end
      end
      if (pop) void'(m_fifo.pop_front());
      if (do_push) m_fifo.push_back(pv);
   endtask

   // Per-cycle comparison of every DUT output against the model
   task automatic check_outputs();
      bit            exp_v;
      logic [2:0]    exp_d;
      logic [IPW-1:0] exp_ip;
      exp_v  = (m_fifo.size() > 0);
      exp_d  = exp_v ? m_fifo[0] : 3'd0;
      exp_ip = IPW'(m_pc * 2);
      tests++;
      if (busy !== (m_mode == M_RUN) || halted !== (m_mode == M_HALT) || error !== m_err ||
          out_valid !== exp_v || out_data !== exp_d || instr_ptr !== exp_ip) begin
         fails++;
         $display("[TB] FAIL cycle %0d outputs: got busy=%0b halted=%0b error=%0b valid=%0b data=%0d ip=%0d, want busy=%0b halted=%0b error=%0b valid=%0b data=%0d ip=%0d",
                  cycle, busy, halted, error, out_valid, out_data, instr_ptr,
                  (m_mode == M_RUN), (m_mode == M_HALT), m_err, exp_v, exp_d, exp_ip);
      end
      if (out_valid && out_ready) dut_out.push_back(out_data);
   endtask

   task automatic tick();
      check_outputs();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cycle++;
   endtask

   task automatic check_eq(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic check_stream(input string name, input int exp_q[$]);
      bit    bad;
      string got_s, exp_s;
      bad = (dut_out.size() != exp_q.size());
      for (int i = 0; i < dut_out.size() && i < exp_q.size(); i++)
         if (int'(dut_out[i]) != exp_q[i]) bad = 1'b1;
      got_s = ""; exp_s = "";
      foreach (dut_out[i]) got_s = $sformatf("%s%0d,", got_s, dut_out[i]);
      foreach (exp_q[i])   exp_s = $sformatf("%s%0d,", exp_s, exp_q[i]);
      tests++;
      if (bad) begin
         fails++;
         $display("[TB] FAIL %s: got [%s] want [%s]", name, got_s, exp_s);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic load_prog();
      for (int i = 0; i < prog_q.size(); i++) begin
         load_valid = 1'b1;
         load_data  = prog_q[i];
         load_last  = (i == prog_q.size() - 1);
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic init_regs(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
      init_valid = 1'b1; init_a = a; init_b = b; init_c = c;
      tick();
      init_valid = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Run until the model is stopped and its FIFO drained; random mode adds backpressure and ignored-input noise
   task automatic run_to_end(input string name, input int budget, input bit rnd);
      int n = 0;
      while ((m_mode == M_RUN || m_fifo.size() != 0) && n < budget) begin
         if (rnd) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (m_mode == M_RUN) begin
               load_valid = ($urandom_range(0, 15) == 0);
               load_last  = $urandom_range(0, 1);
               load_data  = 6'($urandom);
               init_valid = ($urandom_range(0, 15) == 0);
               init_a     = AW'($urandom);
               start      = ($urandom_range(0, 15) == 0);
            end else begin
               load_valid = 1'b0; init_valid = 1'b0; start = 1'b0;
            end
         end
         tick();
         n++;
      end
      load_valid = 1'b0; load_last = 1'b0; init_valid = 1'b0; start = 1'b0;
      tests++;
      if (m_mode == M_RUN || m_fifo.size() != 0) begin
         fails++;
         $display("[TB] FAIL %s timeout: still running after %0d cycles, want stopped", name, budget);
      end
   endtask

   initial begin
      int exp_q[$];
      int n;
      // first edge establishes the model's reset state
      @(posedge clk);
      model_step();
      @(negedge clk);
      rst_n = 1'b1;

      check_eq("reset busy", int'(busy), 0);
      check_eq("reset valid", int'(out_valid), 0);
      check_eq("reset ip", int'(instr_ptr), 0);

      // 729 program
      prog_q = '{6'o01, 6'o54, 6'o30};
      load_prog();
      init_regs(AW'(729), '0, '0);
      out_ready = 1'b1;
      dut_out.delete();
      start_pulse();
      run_to_end("prog729", 300, 1'b0);
      exp_q = '{4, 6, 3, 5, 6, 3, 5, 2, 1, 0};
      check_stream("stream729", exp_q);
      check_eq("729 halted", int'(halted), 1);
      check_eq("729 error", int'(error), 0);
      check_eq("729 ip", int'(instr_ptr), 6);
      check_eq("729 model A", int'(m_a), 0);

      // same program, A=2024, program memory retained
      init_regs(AW'(2024), '0, '0);
      dut_out.delete();
      start_pulse();
      run_to_end("prog2024", 300, 1'b0);
      exp_q = '{4, 2, 5, 6, 7, 7, 7, 7, 3, 1, 0};
      check_stream("stream2024", exp_q);
      check_eq("2024 halted", int'(halted), 1);

      // bst C mod 8
      prog_q = '{6'o26};
      load_prog();
      init_regs('0, '0, AW'(9));
      dut_out.delete();
      start_pulse();
      run_to_end("bst", 50, 1'b0);
      check_eq("bst model B", int'(m_b), 1);
      check_eq("bst outputs", dut_out.size(), 0);
      check_eq("bst halted", int'(halted), 1);

      // backpressure stall with a two-entry FIFO
      prog_q = '{6'o50, 6'o51, 6'o54};
      load_prog();
      init_regs(AW'(10), '0, '0);
      out_ready = 1'b0;
      dut_out.delete();
      start_pulse();
      for (int i = 0; i < 6; i++) tick();
      check_eq("stall busy", int'(busy), 1);
      check_eq("stall ip", int'(instr_ptr), 4);
      check_eq("stall head", int'(out_data), 0);
      out_ready = 1'b1;
      run_to_end("stall drain", 50, 1'b0);
      exp_q = '{0, 1, 2};
      check_stream("stream stall", exp_q);
      check_eq("stall halted", int'(halted), 1);

      // odd jump target with A != 0
      prog_q = '{6'o31};
      load_prog();
      init_regs(AW'(5), '0, '0);
      start_pulse();
      tick();
      check_eq("oddjmp halted", int'(halted), 1);
      check_eq("oddjmp error", int'(error), 1);

      // watchdog on a tight loop
      prog_q = '{6'o30};
      load_prog();
      init_regs(AW'(1), '0, '0);
      start_pulse();
      n = 0;
      while (busy && n < 500) begin n++; tick(); end
      check_eq("watchdog steps", n, MS);
      check_eq("watchdog error", int'(error), 1);

      // reset in the middle of a run
      prog_q = '{6'o01, 6'o54, 6'o30};
      load_prog();
      init_regs(AW'(729), '0, '0);
      out_ready = 1'b0;
      start_pulse();
      for (int i = 0; i < 5; i++) tick();
      do_reset();
      check_eq("midreset valid", int'(out_valid), 0);
      check_eq("midreset busy", int'(busy), 0);
      check_eq("midreset ip", int'(instr_ptr), 0);
      check_eq("midreset error", int'(error), 0);

      // start with no program loaded since reset
      start_pulse();
      check_eq("empty start halted", int'(halted), 1);
      check_eq("empty start error", int'(error), 1);

      // load overflow
      do_reset();
      for (int i = 0; i <= PD; i++) begin
         load_valid = 1'b1; load_data = 6'(i); load_last = 1'b0;
         tick();
      end
      load_valid = 1'b0;
      check_eq("overflow error", int'(error), 1);

      // random programs
      for (int t = 0; t < 40; t++) begin
         do_reset();
         prog_q.delete();
         n = $urandom_range(1, PD);
         for (int i = 0; i < n; i++)
            prog_q.push_back({3'($urandom_range(0, 7)),
                              ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6))});
         load_prog();
         init_regs(AW'($urandom), AW'($urandom), AW'($urandom));
         start_pulse();
         run_to_end("random", 600, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
